// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Purpose  : Read-side drain stage for the async FIFO. Pops words with the
//            rempty/r_inc pair and presents them on a registered valid/ready
//            stream through a 2-entry skid buffer (main + skid registers).
//            r_inc depends only on state and rempty, never on out_ready.
// Ports    : clk        read-domain clock
//            rst        asynchronous active-high reset
//            rempty     FIFO empty flag
//            r_data     FIFO read data (valid while rempty=0)
//            r_inc      FIFO pop strobe
//            out_valid  stream valid (registered)
//            out_ready  consumer ready
//            out_data   stream data (registered, main register)
//            out_par    even parity of out_data (FIFO_RD_STREAM_PARITY_EN only)
//            level      words held, 0..2 (registered)
// Options  : `define FIFO_RD_STREAM_PARITY_EN adds per-entry parity and out_par
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_inc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
`ifdef FIFO_RD_STREAM_PARITY_EN
  output logic                  out_par,
`endif
  output logic [1:0]            level
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [1:0]            level_q, level_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  logic push;
  logic pop;
  // Load selects shared by the data and parity storage so both always move
  // together.
  logic main_from_rd;
  logic main_from_skid;
  logic skid_from_rd;

  // Pop strobe never looks at out_ready; it only needs to know a slot is free.
  assign r_inc = !rst && !rempty && (state_q != ST_FULL);
  assign push  = r_inc;
  assign pop   = valid_q && out_ready;

  always_comb begin
    state_d        = state_q;
    main_from_rd   = 1'b0;
    main_from_skid = 1'b0;
    skid_from_rd   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_from_rd = 1'b1;
          state_d      = ST_HALF;
        end
      end
      ST_HALF: begin
        if (push && pop) begin
          main_from_rd = 1'b1;
        end else if (push) begin
          skid_from_rd = 1'b1;
          state_d      = ST_FULL;
        end else if (pop) begin
          state_d      = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_from_skid = 1'b1;
          state_d        = ST_HALF;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (main_from_rd)   main_d = r_data;
    if (main_from_skid) main_d = skid_q;
    if (skid_from_rd)   skid_d = r_data;
    valid_d = (state_d != ST_EMPTY);
    case (state_d)
      ST_HALF: level_d = 2'd1;
      ST_FULL: level_d = 2'd2;
      default: level_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      level_q <= 2'd0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      level_q <= level_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign level     = level_q;

`ifdef FIFO_RD_STREAM_PARITY_EN
  // Parity is captured at push and travels with its word, so out_par stays
  // aligned with out_data across the skid-to-main move.
  logic par_main_q, par_main_d;
  logic par_skid_q, par_skid_d;

  always_comb begin
    par_main_d = par_main_q;
    par_skid_d = par_skid_q;
    if (main_from_rd)   par_main_d = ^r_data;
    if (main_from_skid) par_main_d = par_skid_q;
    if (skid_from_rd)   par_skid_d = ^r_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_main_q <= 1'b0;
      par_skid_q <= 1'b0;
    end else begin
      par_main_q <= par_main_d;
      par_skid_q <= par_skid_d;
    end
  end

  assign out_par = par_main_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_stream
// Purpose  : Self-checking bench for fifo_rd_stream. A source queue models the
//            FIFO; every popped word is pushed to a scoreboard queue and
//            compared when the stream accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rempty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       r_inc;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] level;
`ifdef FIFO_RD_STREAM_PARITY_EN
  logic       out_par;
`endif

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rempty    (rempty),
    .r_data    (r_data),
    .r_inc     (r_inc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef FIFO_RD_STREAM_PARITY_EN
    .out_par   (out_par),
`endif
    .level     (level)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  bit         hold_empty = 1'b0;
  int         push_cnt = 0;
  int         pop_cnt  = 0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] sb_w;

  // FIFO model and scoreboard. Inputs settle at negedge+1; at negedge+2 the
  // sampled r_inc / out_valid&out_ready are exactly the events of the next edge.
  always begin
    @(negedge clk);
    #1;
    rempty = hold_empty || (src_q.size() == 0);
    r_data = (src_q.size() != 0) ? src_q[0] : 8'h00;
    #1;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      n_checks++;
      if (r_inc && rempty) $display("FAIL r_inc_when_empty: r_inc=%0b rempty=%0b", r_inc, rempty);
      else n_pass++;
      if (prev_hold) begin
        n_checks++;
        if (!(out_valid === 1'b1 && out_data === prev_data))
          $display("FAIL hold_stable: got valid=%0b data=%02h expected valid=1 data=%02h",
                   out_valid, out_data, prev_data);
        else n_pass++;
      end
      if (r_inc && src_q.size() != 0) begin
        exp_q.push_back(src_q.pop_front());
        push_cnt++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_order: got %02h expected no word", out_data);
        end else begin
          sb_w = exp_q.pop_front();
          if (out_data !== sb_w) $display("FAIL sb_order: got %02h expected %02h", out_data, sb_w);
          else n_pass++;
`ifdef FIFO_RD_STREAM_PARITY_EN
          n_checks++;
          if (out_par !== ^sb_w) $display("FAIL sb_par: got %0b expected %0b", out_par, ^sb_w);
          else n_pass++;
`endif
        end
        pop_cnt++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic test_reset;
    int p0;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    src_q.push_back(8'hA5);
    repeat (3) begin
      @(negedge clk); #3;
      n_checks++;
      if (r_inc !== 1'b0) $display("FAIL rst_r_inc: got %0b expected 0", r_inc); else n_pass++;
    end
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", out_valid); else n_pass++;
    n_checks++;
    if (out_data !== 8'h00) $display("FAIL rst_data: got %02h expected 00", out_data); else n_pass++;
    n_checks++;
    if (level !== 2'd0) $display("FAIL rst_level: got %0d expected 0", level); else n_pass++;
`ifdef FIFO_RD_STREAM_PARITY_EN
    n_checks++;
    if (out_par !== 1'b0) $display("FAIL rst_par: got %0b expected 0", out_par); else n_pass++;
`endif
    p0 = push_cnt;
    @(negedge clk);
    rst = 1'b0;
    #3;
    n_checks++;
    if (r_inc !== 1'b1) $display("FAIL single_r_inc_hi: got %0b expected 1", r_inc); else n_pass++;
    @(negedge clk); #3;
    n_checks++;
    if (r_inc !== 1'b0) $display("FAIL single_r_inc_lo: got %0b expected 0", r_inc); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b expected 1", out_valid); else n_pass++;
    n_checks++;
    if (out_data !== 8'hA5) $display("FAIL single_data: got %02h expected a5", out_data); else n_pass++;
    n_checks++;
    if (level !== 2'd1) $display("FAIL single_level: got %0d expected 1", level); else n_pass++;
    @(negedge clk); #3;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL single_valid_off: got %0b expected 0", out_valid); else n_pass++;
    n_checks++;
    if (level !== 2'd0) $display("FAIL single_level_off: got %0d expected 0", level); else n_pass++;
    n_checks++;
    if (push_cnt - p0 !== 1) $display("FAIL single_pops: got %0d expected 1", push_cnt - p0); else n_pass++;
  endtask

  task automatic test_stream;
    int vcnt = 0;
    int run = 0;
    int best = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    repeat (24) begin
      @(negedge clk); #3;
      if (out_valid) begin
        vcnt++;
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      n_checks++;
      if (level > 2'd1) $display("FAIL stream_level: got %0d expected <=1", level); else n_pass++;
    end
    n_checks++;
    if (vcnt !== 16) $display("FAIL stream_valid_cnt: got %0d expected 16", vcnt); else n_pass++;
    n_checks++;
    if (best !== 16) $display("FAIL stream_run: got %0d expected 16", best); else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL stream_drain: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure;
    int p0;
    @(negedge clk);
    out_ready = 1'b0;
    p0 = push_cnt;
    for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h10 + i));
    repeat (6) @(negedge clk);
    #3;
    n_checks++;
    if (push_cnt - p0 !== 2) $display("FAIL bp_pops: got %0d expected 2", push_cnt - p0); else n_pass++;
    n_checks++;
    if (level !== 2'd2) $display("FAIL bp_level: got %0d expected 2", level); else n_pass++;
    n_checks++;
    if (r_inc !== 1'b0) $display("FAIL bp_r_inc: got %0b expected 0", r_inc); else n_pass++;
    n_checks++;
    if (out_data !== 8'h10) $display("FAIL bp_data: got %02h expected 10", out_data); else n_pass++;
    @(negedge clk);
    out_ready = 1'b1;
    #3;
    n_checks++;
    if (r_inc !== 1'b0) $display("FAIL bp_r_inc_full: got %0b expected 0", r_inc); else n_pass++;
    @(negedge clk); #3;
    n_checks++;
    if (level !== 2'd1) $display("FAIL rec_level: got %0d expected 1", level); else n_pass++;
    n_checks++;
    if (r_inc !== 1'b1) $display("FAIL rec_r_inc: got %0b expected 1", r_inc); else n_pass++;
    n_checks++;
    if (out_data !== 8'h11) $display("FAIL rec_data: got %02h expected 11", out_data); else n_pass++;
    for (int i = 0; i < 15; i++) begin
      if (i != 0) begin
        @(negedge clk); #3;
      end
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL rec_gap: got %0b expected 1 at word %0d", out_valid, i); else n_pass++;
    end
    repeat (3) @(negedge clk);
    #3;
    n_checks++;
    if (exp_q.size() !== 0 || src_q.size() !== 0)
      $display("FAIL bp_drain: got %0d/%0d expected 0/0", exp_q.size(), src_q.size());
    else n_pass++;
  endtask

  task automatic test_random;
    int p0;
    int q0;
    p0 = push_cnt;
    q0 = pop_cnt;
    repeat (1000) begin
      @(negedge clk);
      out_ready  = 1'($urandom_range(0, 1));
      hold_empty = ($urandom_range(0, 3) == 0);
      if (src_q.size() < 2) src_q.push_back(8'($urandom_range(0, 255)));
    end
    @(negedge clk);
    out_ready  = 1'b1;
    hold_empty = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    n_checks++;
    if (exp_q.size() !== 0 || src_q.size() !== 0)
      $display("FAIL rand_drain: got %0d/%0d expected 0/0", exp_q.size(), src_q.size());
    else n_pass++;
    n_checks++;
    if (pop_cnt - q0 !== push_cnt - p0)
      $display("FAIL rand_count: got %0d expected %0d", pop_cnt - q0, push_cnt - p0);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    int t = 0;
    int p0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h40 + i));
    do begin
      @(negedge clk); #3;
      t++;
    end while (level !== 2'd2 && t < 20);
    n_checks++;
    if (level !== 2'd2) $display("FAIL mr_fill: got %0d expected 2", level); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #3;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL mr_valid: got %0b expected 0", out_valid); else n_pass++;
    n_checks++;
    if (level !== 2'd0) $display("FAIL mr_level: got %0d expected 0", level); else n_pass++;
    n_checks++;
    if (r_inc !== 1'b0) $display("FAIL mr_r_inc: got %0b expected 0", r_inc); else n_pass++;
    p0 = push_cnt;
    repeat (3) begin
      @(negedge clk); #3;
      n_checks++;
      if (r_inc !== 1'b0) $display("FAIL mr_r_inc_hold: got %0b expected 0", r_inc); else n_pass++;
    end
    n_checks++;
    if (push_cnt !== p0) $display("FAIL mr_no_pop: got %0d expected %0d", push_cnt, p0); else n_pass++;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    n_checks++;
    if (exp_q.size() !== 0 || src_q.size() !== 0)
      $display("FAIL mr_drain: got %0d/%0d expected 0/0", exp_q.size(), src_q.size());
    else n_pass++;
  endtask

`ifdef FIFO_RD_STREAM_PARITY_EN
  task automatic test_parity;
    logic [7:0] pw[4];
    logic       pp[4];
    pw = '{8'h01, 8'h03, 8'hFF, 8'h80};
    pp = '{1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(pw[i]);
    repeat (4) @(negedge clk);
    #3;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data !== pw[i]) $display("FAIL par_data: got %02h expected %02h", out_data, pw[i]); else n_pass++;
      n_checks++;
      if (out_par !== pp[i]) $display("FAIL par_bit: got %0b expected %0b for %02h", out_par, pp[i], pw[i]); else n_pass++;
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
      #3;
    end
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL par_drain: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_mid_reset();
`ifdef FIFO_RD_STREAM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage for the async FIFO. Sits in the read clock domain, directly downstream of the FIFO read port. It pops words using the FIFO's `rempty`/`r_inc` pair and presents them on a registered valid/ready stream to the consumer, such as the UART TX front end. A 2-entry skid buffer gives full throughput with no combinational path from `out_ready` back to `r_inc`.

## Interface
- `DATA_WIDTH`, default 8: width of FIFO read data and stream data.

- `clk` in 1: read-domain clock; the same clock as the FIFO read side.
- `rst` in 1: asynchronous, active-high reset.
- `rempty` in 1: FIFO empty flag, synchronous to `clk`.
- `r_data` in DATA_WIDTH: FIFO read data. Combinational from the FIFO read address, valid whenever `rempty`=0.
- `r_inc` out 1: FIFO pop strobe. One word is consumed on each `clk` edge where it is high.
- `out_valid` out 1: stream data valid.
- `out_ready` in 1: consumer accepts the word on the current edge.
- `out_data` out DATA_WIDTH: stream data (registered).
- `level` out 2: number of words held (0..2), registered.
- `out_par` out 1: even parity of `out_data`, registered. Present only with `FIFO_RD_STREAM_PARITY_EN`.

## Operation
- Storage is a main register (drives `out_data`) and a skid register. The state machine has three states:
  - EMPTY: level 0.
  - HALF: main holds a word.
  - FULL: main and skid both hold words.
- Definitions: push = `r_inc`; pop = `out_valid` & `out_ready`.
- `r_inc` = !`rst` & !`rempty` & (state != FULL).
  - It is combinational from state and `rempty` only; it never depends on `out_ready`.
  - It is forced 0 while `rst` is high.
- Transitions, evaluated on each `clk` edge:
  - EMPTY, push: main <= `r_data`, go to HALF.
  - HALF, push and pop: main <= `r_data`, stay in HALF.
  - HALF, push only: skid <= `r_data`, go to FULL.
  - HALF, pop only: go to EMPTY.
  - FULL, pop: main <= skid, go to HALF. Push is impossible in FULL.
  - Any state, no event: hold.
- `out_valid` = (state != EMPTY), registered alongside the state.
- `level` = 0, 1 or 2 for EMPTY, HALF or FULL.
- While `out_valid`=1 and `out_ready`=0, `out_data` is held stable. The word is never changed or dropped before it is accepted.
- Words leave in strict FIFO order. There is no duplication and no loss.
- `out_ready` asserted while `out_valid`=0 has no effect.
- Reset mid-operation discards both entries. On `rst` release the block restarts from EMPTY. The FIFO pointers are not the block's concern; nothing is popped during reset.

## Timing
- Values during and after reset:
  - `out_valid`=0, `out_data`=0, `level`=0, `out_par`=0.
  - State is EMPTY.
  - `r_inc`=0 while `rst` is high.
- Latency: if `rempty` falls before edge N, `r_inc` is high in the cycle before N. `out_valid`=1 with that word from edge N onward (1 cycle).
- Throughput: with `out_ready` held high and the FIFO non-empty, one word per cycle. The block stays in HALF.
- Backpressure: after `out_ready` drops, at most 2 words are buffered, then `r_inc` deasserts.
- Recovery: one cycle after `out_ready` returns, the skid word moves to main and `r_inc` re-enables in the same cycle the state reaches HALF.
- Empty FIFO: `rempty`=1 holds `r_inc`=0 regardless of state. The buffer drains normally.

## Configuration
- `FIFO_RD_STREAM_PARITY_EN` defined:
  - Adds the `out_par` port.
  - A parity bit is stored with each entry: main and skid each carry `^r_data`, computed at push.
  - `out_par` always matches `out_data`, including on the skid-to-main move.
- Not defined: the `out_par` port and the parity storage are absent. All other behaviour is identical.

## Test plan
- Reset then single word: `rst` pulse, FIFO presents 0xA5 (`rempty`=0 for one cycle), `out_ready`=1. Required: `r_inc`=1 for exactly one cycle, then `out_valid`=1 with `out_data`=0xA5 one cycle later, `level`=1, then back to 0.
- Streaming: 16 words 0x00..0x0F with `out_ready`=1. Required: 16 consecutive `out_valid` cycles, in-order data, `level` never exceeds 1.
- Backpressure: stream 0x10.. with `out_ready`=0 from the start. Required: exactly 2 pops, `level`=2, `r_inc`=0, `out_data`=0x10 held. Then raise `out_ready`. Required: 0x10, 0x11, 0x12... delivered with no gaps or loss.
- Random `out_ready` and `rempty` over 1000 cycles. Required: output sequence equals pop sequence, and `out_data` is stable whenever `out_valid`&!`out_ready`.
- Mid-operation reset in FULL (`level`=2). Required: `out_valid`=0, `level`=0 and `r_inc`=0 immediately on `rst`, with no pop until release.
- With `FIFO_RD_STREAM_PARITY_EN`: words 0x01, 0x03, 0xFF, 0x80. Required: `out_par` = 1, 0, 0, 1, aligned with `out_data`, including across a skid transfer.
